// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int unsigned DEF_DW     = 32;
    localparam int unsigned DEF_AW     = 5;
    localparam int unsigned DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    pending
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DEPTH-1:0] pend_q;

    // Set is applied after clear so a same-address set/clear leaves the bit high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else if (flush) begin
            pend_q <= '0;
        end else begin
            if (clr_en) pend_q[clr_addr] <= 1'b0;
            if (set_en) pend_q[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            pending[i] = pend_q[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with bypass, pending scoreboard
// and a sequential clear engine that sweeps the array instead of resetting it.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned NUM_RD    = DEF_NUM_RD,
    parameter int unsigned ZERO_REG0 = 1,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_pending,
    input  logic                 pend_set,
    input  logic [AW-1:0]        pend_addr,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam int unsigned DEPTH = 2 ** AW;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            busy, last, flush;
    logic            wr_eff, set_eff, set_hits_wr;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   ra  [NUM_RD];
    logic            hit [NUM_RD];
    logic [NUM_RD-1:0] pend_look;

    assign busy        = (state_q == CLEAR);
    assign last        = busy && (ptr_q == '1);
    assign clr_busy    = busy;
    assign clr_done    = last;
    assign flush       = (state_q == IDLE) && clr_req;
    assign wr_eff      = !busy && wr_en && !((ZERO_REG0 != 0) && (wr_addr == '0));
    assign set_eff     = !busy && pend_set && !((ZERO_REG0 != 0) && (pend_addr == '0));
    assign set_hits_wr = pend_set && (pend_addr == wr_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (last) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage has no reset; the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr_q] <= '0;
        end else if (wr_eff) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        assign ra[g]  = rd_addr[g*AW +: AW];
        assign hit[g] = (BYPASS != 0) && wr_eff && (wr_addr == ra[g]);
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        if (!busy) begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if ((ZERO_REG0 != 0) && (ra[i] == '0)) begin
                    rd_data[i*DW +: DW] = '0;
                end else if (hit[i]) begin
                    rd_data[i*DW +: DW] = wr_data;
                end else begin
                    rd_data[i*DW +: DW] = mem[ra[i]];
                end
                rd_pending[i] = pend_look[i] && !(hit[i] && !set_hits_wr);
            end
        end
    end

    regfile_scoreboard #(
        .AW     (AW),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .set_en   (set_eff),
        .set_addr (pend_addr),
        .clr_en   (wr_eff),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .pending  (pend_look)
    );

endmodule
